// File: rtl/wt_pkg.sv
// wt_pkg: shared mode encoding, field limits, key indices and wrap helper for the LCD watch time keeper
package wt_pkg;
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_t;
  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX = 7'd59;
  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam int KEY_MODE = 0;
  localparam int KEY_UP = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_CLR = 3;
  localparam int KEY_RUN = 4;
  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] max, input logic dn);
    return dn ? ((v == 7'd0) ? max : v - 7'd1) : ((v == max) ? 7'd0 : v + 7'd1);
  endfunction
endpackage

// File: rtl/wt_key_debounce.sv
// wt_key_debounce: one key through 2-FF sync, DEB_CYCLES stability filter and registered press pulse (CLK, RESET, key -> press)
module wt_key_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, lvl, lvl_q, done;
  logic [CW-1:0] cnt;
  assign done = (s2 != lvl) && (cnt == CW'(DEB_CYCLES - 1));
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      lvl_q <= 1'b0;
      press <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      cnt <= (s2 == lvl || done) ? '0 : cnt + CW'(1);
      lvl <= done ? s2 : lvl;
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
    end
endmodule

// File: rtl/wt_time_keeper.sv
// wt_time_keeper: HH:MM:SS keeper with RUN/SET mode machine (CLK, RESET, KEY[4:0] -> HOUR, MIN, SEC, MODE, BLINK, SEC_TICK)
module wt_time_keeper
  import wt_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int DEB_CYCLES = 1000,
  parameter int BLINK_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] KEY,
  output logic [6:0] HOUR,
  output logic [6:0] MIN,
  output logic [6:0] SEC,
  output logic [1:0] MODE,
  output logic       BLINK,
  output logic       SEC_TICK
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  mode_t state, nxt;
  logic [4:0] ev;
  logic [PW-1:0] pre, pre_n;
  logic [BW-1:0] bcnt;
  logic [6:0] hour_n, min_n, sec_n;
  logic run, chg, tick, adj, dn, pre_end, blink_end;
  for (genvar i = 0; i < 5; i++) begin : g_key
    wt_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .CLK(CLK),
      .RESET(RESET),
      .key(KEY[i]),
      .press(ev[i])
    );
  end
  assign run = state == MODE_RUN;
  assign pre_end = pre == PW'(TICK_DIV - 1);
  assign blink_end = bcnt == BW'(BLINK_DIV - 1);
  assign MODE = state;
  always_comb begin
    nxt = (ev[KEY_RUN] && !run) ? MODE_RUN : ev[KEY_MODE] ? mode_t'(state + 2'd1) : state;
    chg = nxt != state;
    tick = run && pre_end && !ev[KEY_CLR];
    adj = !chg && !run && (ev[KEY_UP] ^ ev[KEY_DOWN]);
    dn = ev[KEY_DOWN];
    pre_n = (!run || chg || ev[KEY_CLR] || pre_end) ? '0 : pre + PW'(1);
    sec_n = ev[KEY_CLR] ? 7'd0 : tick ? wrap_step(SEC, SEC_MAX, 1'b0) :
            (adj && state == MODE_SET_S) ? wrap_step(SEC, SEC_MAX, dn) : SEC;
    min_n = (tick && SEC == SEC_MAX) ? wrap_step(MIN, MIN_MAX, 1'b0) :
            (adj && state == MODE_SET_M) ? wrap_step(MIN, MIN_MAX, dn) : MIN;
    hour_n = (tick && SEC == SEC_MAX && MIN == MIN_MAX) ? wrap_step(HOUR, HOUR_MAX, 1'b0) :
             (adj && state == MODE_SET_H) ? wrap_step(HOUR, HOUR_MAX, dn) : HOUR;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= MODE_RUN;
    else state <= nxt;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      pre <= '0;
      bcnt <= '0;
      HOUR <= 7'd0;
      MIN <= 7'd0;
      SEC <= 7'd0;
      BLINK <= 1'b0;
      SEC_TICK <= 1'b0;
    end else begin
      pre <= pre_n;
      HOUR <= hour_n;
      MIN <= min_n;
      SEC <= sec_n;
      SEC_TICK <= tick;
      bcnt <= (run || chg || blink_end) ? '0 : bcnt + BW'(1);
      BLINK <= (run || chg) ? 1'b0 : blink_end ? ~BLINK : BLINK;
    end
endmodule
